// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32-entry register file: three writeback sources share
// one write port through a one-entry output stage. Build option: REGARB_FIXED_PRIO_EN.
module regfile_write_arbiter #(
  parameter int DataSize = 32,
  parameter int AddrSize = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                alu_valid,
  input  logic [AddrSize-1:0] alu_addr,
  input  logic [DataSize-1:0] alu_data,
  output logic                alu_ready,
  input  logic                load_valid,
  input  logic [AddrSize-1:0] load_addr,
  input  logic [DataSize-1:0] load_data,
  output logic                load_ready,
  input  logic                link_valid,
  input  logic [AddrSize-1:0] link_addr,
  input  logic [DataSize-1:0] link_data,
  output logic                link_ready,
  input  logic                wb_slot,
  input  logic                fetch_req,
  input  logic [AddrSize-1:0] fetch_ra_addr,
  input  logic [AddrSize-1:0] fetch_rb_addr,
  input  logic [AddrSize-1:0] fetch_rt_addr,
  output logic [AddrSize-1:0] write_reg_addr,
  output logic [DataSize-1:0] write_reg_data,
  output logic                do_reg_write,
  output logic                enable_reg_write,
  output logic                enable_reg_fetch,
  output logic                fetch_stall
);

  // Handshake: a requester holds valid with stable addr/data until it sees ready;
  // a transfer happens on the edge where valid & ready are both 1. Ready never
  // depends on anything but the current inputs and registered state.

  logic                active;
  logic                out_valid;
  logic [AddrSize-1:0] out_addr;
  logic [DataSize-1:0] out_data;
  logic                accept;
  logic [2:0]          req;
  logic [2:0]          gnt;
  logic                transfer;
  logic [AddrSize-1:0] win_addr;
  logic [DataSize-1:0] win_data;
  logic                hit;

  assign req    = {link_valid, load_valid, alu_valid};
  // active keeps every ready low until the first edge after reset release
  assign accept = active & (~out_valid | wb_slot);

`ifdef REGARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    if (accept) begin
      if (req[2])      gnt = 3'b100;
      else if (req[1]) gnt = 3'b010;
      else if (req[0]) gnt = 3'b001;
    end
  end
`else
  logic [1:0] last;
  logic [1:0] cand;

  // Search last+1, last+2, last+3 (mod 3); first pending requester wins.
  always_comb begin
    gnt  = '0;
    cand = last;
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        if (gnt == 3'b000 && req[cand]) gnt[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last <= 2'd2;
    end else if (gnt[0]) begin
      last <= 2'd0;
    end else if (gnt[1]) begin
      last <= 2'd1;
    end else if (gnt[2]) begin
      last <= 2'd2;
    end
  end
`endif

  assign alu_ready  = gnt[0];
  assign load_ready = gnt[1];
  assign link_ready = gnt[2];
  assign transfer   = |gnt;

  always_comb begin
    win_addr = alu_addr;
    win_data = alu_data;
    if (gnt[1]) begin
      win_addr = load_addr;
      win_data = load_data;
    end else if (gnt[2]) begin
      win_addr = link_addr;
      win_data = link_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      active <= 1'b1;
      if (transfer) begin
        out_valid <= 1'b1;
        out_addr  <= win_addr;
        out_data  <= win_data;
      end else if (wb_slot) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign do_reg_write     = out_valid;
  assign enable_reg_write = out_valid & wb_slot;
  assign write_reg_addr   = out_addr;
  assign write_reg_data   = out_data;

  function automatic logic addr_hit(input logic [AddrSize-1:0] a,
                                    input logic [AddrSize-1:0] ra,
                                    input logic [AddrSize-1:0] rb,
                                    input logic [AddrSize-1:0] rt);
    return (a == ra) || (a == rb) || (a == rt);
  endfunction

  // A draining stage is still a hit: the file reads the old value on that edge.
  always_comb begin
    hit = 1'b0;
    if (out_valid  && addr_hit(out_addr,  fetch_ra_addr, fetch_rb_addr, fetch_rt_addr)) hit = 1'b1;
    if (alu_valid  && addr_hit(alu_addr,  fetch_ra_addr, fetch_rb_addr, fetch_rt_addr)) hit = 1'b1;
    if (load_valid && addr_hit(load_addr, fetch_ra_addr, fetch_rb_addr, fetch_rt_addr)) hit = 1'b1;
    if (link_valid && addr_hit(link_addr, fetch_ra_addr, fetch_rb_addr, fetch_rt_addr)) hit = 1'b1;
  end

  assign enable_reg_fetch = fetch_req & ~hit;
  assign fetch_stall      = fetch_req & hit;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter; expectations follow the build
// option REGARB_FIXED_PRIO_EN when defined.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid, load_valid, link_valid;
  logic [4:0]  alu_addr, load_addr, link_addr;
  logic [31:0] alu_data, load_data, link_data;
  logic        alu_ready, load_ready, link_ready;
  logic        wb_slot, fetch_req;
  logic [4:0]  fetch_ra_addr, fetch_rb_addr, fetch_rt_addr;
  logic [4:0]  write_reg_addr;
  logic [31:0] write_reg_data;
  logic        do_reg_write, enable_reg_write, enable_reg_fetch, fetch_stall;
  logic [2:0]  rdy;

  int checks = 0;
  int errors = 0;

  assign rdy = {link_ready, load_ready, alu_ready};

  regfile_write_arbiter #(.DataSize(32), .AddrSize(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready),
    .link_valid(link_valid), .link_addr(link_addr), .link_data(link_data), .link_ready(link_ready),
    .wb_slot(wb_slot), .fetch_req(fetch_req),
    .fetch_ra_addr(fetch_ra_addr), .fetch_rb_addr(fetch_rb_addr), .fetch_rt_addr(fetch_rt_addr),
    .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
    .do_reg_write(do_reg_write), .enable_reg_write(enable_reg_write),
    .enable_reg_fetch(enable_reg_fetch), .fetch_stall(fetch_stall)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; load_valid = 0; link_valid = 0;
    alu_addr = 0; load_addr = 0; link_addr = 0;
    alu_data = 0; load_data = 0; link_data = 0;
    wb_slot = 0; fetch_req = 0;
    fetch_ra_addr = 0; fetch_rb_addr = 0; fetch_rt_addr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    logic [2:0] first;
`ifdef REGARB_FIXED_PRIO_EN
    first = 3'b100;
`else
    first = 3'b001;
`endif
    do_reset();
    checks++; if (do_reg_write !== 1'b0) begin errors++; $display("FAIL reset_do_write: got %b exp 0", do_reg_write); end
    alu_valid = 1; alu_addr = 5; alu_data = 32'h1234;
    #2;
    checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL reset_pre_grant: got %b exp 001", rdy); end
    tick();
    alu_valid = 0;
    #2;
    checks++; if (do_reg_write !== 1'b1 || write_reg_addr !== 5'd5 || write_reg_data !== 32'h1234) begin
      errors++; $display("FAIL reset_pending: got v=%b a=%0d d=%h exp v=1 a=5 d=1234", do_reg_write, write_reg_addr, write_reg_data); end
    reset_n = 0; wb_slot = 1;
    alu_valid = 1; load_valid = 1; link_valid = 1;
    alu_addr = 1; load_addr = 2; link_addr = 3;
    #1;
    checks++; if (do_reg_write !== 1'b0 || enable_reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got do=%b en=%b exp 0 0", do_reg_write, enable_reg_write); end
    checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL reset_ready_low: got %b exp 000", rdy); end
    tick();
    reset_n = 1;
    #2;
    checks++; if (rdy !== 3'b000 || enable_reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_before_edge: got rdy=%b en=%b exp 000 0", rdy, enable_reg_write); end
    tick();
    #2;
    checks++; if (rdy !== first) begin errors++; $display("FAIL reset_first_grant: got %b exp %b", rdy, first); end
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [2:0]  g [3];
    logic [4:0]  a [3];
    logic [31:0] d [3];
`ifdef REGARB_FIXED_PRIO_EN
    g[0] = 3'b100; g[1] = 3'b010; g[2] = 3'b001;
    a[0] = 30; a[1] = 2; a[2] = 1;
    d[0] = 32'h400; d[1] = 32'h22; d[2] = 32'h11;
`else
    g[0] = 3'b001; g[1] = 3'b010; g[2] = 3'b100;
    a[0] = 1; a[1] = 2; a[2] = 30;
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h400;
`endif
    do_reset();
    alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
    load_valid = 1; load_addr = 2; load_data = 32'h22;
    link_valid = 1; link_addr = 30; link_data = 32'h400;
    wb_slot = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (rdy !== g[i]) begin errors++; $display("FAIL contention_grant%0d: got %b exp %b", i, rdy, g[i]); end
      if (i > 0) begin
        checks++; if (enable_reg_write !== 1'b1 || write_reg_addr !== a[i-1] || write_reg_data !== d[i-1]) begin
          errors++; $display("FAIL contention_commit%0d: got en=%b a=%0d d=%h exp 1 %0d %h", i-1, enable_reg_write, write_reg_addr, write_reg_data, a[i-1], d[i-1]); end
      end
      tick();
      if (g[i][0]) alu_valid = 0;
      if (g[i][1]) load_valid = 0;
      if (g[i][2]) link_valid = 0;
    end
    #2;
    checks++; if (enable_reg_write !== 1'b1 || write_reg_addr !== a[2] || write_reg_data !== d[2] || rdy !== 3'b000) begin
      errors++; $display("FAIL contention_commit2: got en=%b a=%0d d=%h rdy=%b exp 1 %0d %h 000", enable_reg_write, write_reg_addr, write_reg_data, rdy, a[2], d[2]); end
    tick();
    #2;
    checks++; if (do_reg_write !== 1'b0) begin errors++; $display("FAIL contention_drained: got %b exp 0", do_reg_write); end
    clear_inputs();
  endtask

  task automatic test_back_pressure();
    do_reset();
    alu_valid = 1; alu_addr = 7; alu_data = 32'hAA;
    #2;
    checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL bp_accept_empty: got %b exp 001", rdy); end
    tick();
    alu_valid = 0;
    load_valid = 1; load_addr = 8; load_data = 32'hBB;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (do_reg_write !== 1'b1 || enable_reg_write !== 1'b0 || rdy !== 3'b000) begin
        errors++; $display("FAIL bp_hold%0d: got do=%b en=%b rdy=%b exp 1 0 000", i, do_reg_write, enable_reg_write, rdy); end
      tick();
    end
    wb_slot = 1;
    #2;
    checks++; if (enable_reg_write !== 1'b1 || write_reg_addr !== 5'd7 || write_reg_data !== 32'hAA || rdy !== 3'b010) begin
      errors++; $display("FAIL bp_release: got en=%b a=%0d d=%h rdy=%b exp 1 7 aa 010", enable_reg_write, write_reg_addr, write_reg_data, rdy); end
    tick();
    load_valid = 0;
    #2;
    checks++; if (enable_reg_write !== 1'b1 || write_reg_addr !== 5'd8 || write_reg_data !== 32'hBB) begin
      errors++; $display("FAIL bp_second: got en=%b a=%0d d=%h exp 1 8 bb", enable_reg_write, write_reg_addr, write_reg_data); end
    clear_inputs();
  endtask

  task automatic test_hazard();
    do_reset();
    alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
    tick();
    alu_valid = 0;
    fetch_req = 1; fetch_ra_addr = 4; fetch_rb_addr = 1; fetch_rt_addr = 2;
    #2;
    checks++; if (fetch_stall !== 1'b1 || enable_reg_fetch !== 1'b0) begin
      errors++; $display("FAIL hazard_stage: got stall=%b en=%b exp 1 0", fetch_stall, enable_reg_fetch); end
    wb_slot = 1;
    #2;
    checks++; if (fetch_stall !== 1'b1 || enable_reg_fetch !== 1'b0 || enable_reg_write !== 1'b1) begin
      errors++; $display("FAIL hazard_draining: got stall=%b en=%b wr=%b exp 1 0 1", fetch_stall, enable_reg_fetch, enable_reg_write); end
    tick();
    wb_slot = 0;
    #2;
    checks++; if (fetch_stall !== 1'b0 || enable_reg_fetch !== 1'b1) begin
      errors++; $display("FAIL hazard_after_drain: got stall=%b en=%b exp 0 1", fetch_stall, enable_reg_fetch); end
    // requester-side hazard on a not-yet-granted load
    load_valid = 1; load_addr = 9; load_data = 32'h99;
    fetch_ra_addr = 1; fetch_rb_addr = 2; fetch_rt_addr = 9;
    #2;
    checks++; if (fetch_stall !== 1'b1 || enable_reg_fetch !== 1'b0) begin
      errors++; $display("FAIL hazard_req_hit: got stall=%b en=%b exp 1 0", fetch_stall, enable_reg_fetch); end
    fetch_rt_addr = 10;
    #2;
    checks++; if (fetch_stall !== 1'b0 || enable_reg_fetch !== 1'b1) begin
      errors++; $display("FAIL hazard_req_miss: got stall=%b en=%b exp 0 1", fetch_stall, enable_reg_fetch); end
    fetch_req = 0; fetch_rt_addr = 9;
    #2;
    checks++; if (fetch_stall !== 1'b0 || enable_reg_fetch !== 1'b0) begin
      errors++; $display("FAIL hazard_no_req: got stall=%b en=%b exp 0 0", fetch_stall, enable_reg_fetch); end
    // register 0 is an ordinary register for hazard purposes
    load_addr = 0; fetch_req = 1; fetch_ra_addr = 0; fetch_rt_addr = 10;
    #2;
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL hazard_r0: got %b exp 1", fetch_stall); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int commits;
    commits = 0;
    do_reset();
    wb_slot = 1;
    for (int i = 1; i <= 8; i++) begin
      alu_valid = 1; alu_addr = 5'(i); alu_data = 32'(i * 16);
      #2;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b exp 1", i, alu_ready); end
      if (enable_reg_write === 1'b1) commits++;
      if (i > 1) begin
        checks++; if (enable_reg_write !== 1'b1 || write_reg_addr !== 5'(i - 1) || write_reg_data !== 32'((i - 1) * 16)) begin
          errors++; $display("FAIL stream_commit%0d: got en=%b a=%0d d=%h exp 1 %0d %h", i-1, enable_reg_write, write_reg_addr, write_reg_data, i-1, (i-1)*16); end
      end
      tick();
    end
    alu_valid = 0;
    #2;
    if (enable_reg_write === 1'b1) commits++;
    checks++; if (write_reg_addr !== 5'd8 || write_reg_data !== 32'h80) begin
      errors++; $display("FAIL stream_last: got a=%0d d=%h exp 8 80", write_reg_addr, write_reg_data); end
    checks++; if (commits !== 8) begin errors++; $display("FAIL stream_count: got %0d exp 8", commits); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_contention();
    test_back_pressure();
    test_hazard();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single write port of the 32-entry register file among three writeback sources: ALU result, load data and link address.
- Sequences the port's enables: holds a granted write in a one-entry output stage until the core's writeback slot (`wb_slot`) opens, then drives the write strobes.
- Gates operand fetch so that a read never returns a value still waiting in the arbiter.
- Sits between the execute/memory stages and the register file; its outputs connect directly to the register file's write and fetch-enable inputs.

## Interface
Parameters:
- `DataSize`, 32, register data width
- `AddrSize`, 5, register address width

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `alu_valid` / `load_valid` / `link_valid`  in  1  requester has a write pending
- `alu_addr` / `load_addr` / `link_addr`  in  AddrSize  destination register
- `alu_data` / `load_data` / `link_data`  in  DataSize  write data
- `alu_ready` / `load_ready` / `link_ready`  out  1  grant; transfer when valid&ready
- `wb_slot`  in  1  register file write phase is open this cycle
- `fetch_req`  in  1  decode wants to fetch operands
- `fetch_ra_addr` / `fetch_rb_addr` / `fetch_rt_addr`  in  AddrSize  operands to fetch
- `write_reg_addr`  out  AddrSize  to register file
- `write_reg_data`  out  DataSize  to register file
- `do_reg_write`  out  1  output stage holds a write
- `enable_reg_write`  out  1  write commits at next edge
- `enable_reg_fetch`  out  1  fetch permitted
- `fetch_stall`  out  1  fetch blocked by a RAW hazard

## Operation
- **Output stage:** registers `out_valid`, `out_addr`, `out_data`.
  - `do_reg_write = out_valid`
  - `enable_reg_write = out_valid & wb_slot`
  - `write_reg_addr` and `write_reg_data` are driven directly from the stage.
- **Accept condition:** `accept = ~out_valid | wb_slot`.
  - A stage that drains and refills in the same cycle gives back-to-back writes.
- **Arbitration:** evaluated only when `accept` is 1.
  - At most one `*_ready` is high per cycle, and only for a requester whose valid is 1.
  - When `accept` is 0, all readys are 0.
- **Round-robin:** pointer `last` holds the index of the last port granted (0=alu, 1=load, 2=link).
  - Search order: `last+1`, `last+2`, `last+3`, all mod 3.
  - `last` updates only on a completed transfer.
- **Transfer:** the winner's addr and data load into the output stage and `out_valid` becomes 1.
- **Drain with no transfer:** if `wb_slot & out_valid` and nothing transfers, `out_valid` becomes 0.
- **Hazard:**
  - `hit` = (`out_valid` and `out_addr` equals any fetch address) OR (any valid requester's addr equals any fetch address).
  - `enable_reg_fetch = fetch_req & ~hit`
  - `fetch_stall = fetch_req & hit`
  - A draining stage still counts as a hit, because the register file reads the old value in the same edge.
- **Address width:** all widths are exact. Register 0 gets no special treatment: it is writable and can cause hazards.

## Timing
- **Reset values:** `out_valid=0`, `out_addr=0`, `out_data=0`, `last=2` (ALU wins first).
  - Therefore `do_reg_write=0`, `enable_reg_write=0`, and every ready is 0 until the first edge after `reset_n` deasserts.
- **Combinational outputs:** readys, `enable_reg_fetch` and `fetch_stall` depend on the current cycle's inputs.
- **Latency:**
  - Transfer in cycle N puts the write in the output stage in cycle N+1.
  - The register file commits at the first edge in which `wb_slot=1`, i.e. at the end of cycle N+1 at the earliest.
- **Throughput:** one write per cycle while `wb_slot` stays high.
- **Simultaneous requests:** exactly one is granted. The others keep valid asserted and their addr/data stable until granted.
- **Reset mid-operation:** a pending output-stage write is discarded, the pointer returns to 2, and nothing reaches the register file.
- **`wb_slot` high with stage empty:** no write occurs, and a transfer in the same cycle is still accepted.

## Configuration
- **`REGARB_FIXED_PRIO_EN` defined:** fixed priority link > load > alu replaces round-robin. The `last` register is removed.
- **`REGARB_FIXED_PRIO_EN` undefined (default):** round-robin as specified above.
- Reset, handshake, hazard and timing behaviour are identical in both builds.

## Test plan
- **Reset:** `reset_n` pulsed low while `out_valid=1` (pending write r5=0x1234) -> `do_reg_write=0`, no commit, ALU granted first afterwards.
- **Contention:** alu(r1=0x11), load(r2=0x22) and link(r30=0x400) held valid, `wb_slot=1` -> grants in order alu, load, link on three consecutive cycles; writes committed in that order. With `REGARB_FIXED_PRIO_EN`: link, load, alu.
- **Back-pressure:** `wb_slot=0` for 3 cycles with alu r7=0xAA pending -> `do_reg_write=1`, `enable_reg_write=0`, all readys 0; the fourth cycle's `wb_slot=1` -> `enable_reg_write=1` and load is granted in the same cycle.
- **Hazard:** output stage holds r4 and `fetch_req` with `ra=4` -> `fetch_stall=1`, `enable_reg_fetch=0`; the cycle after drain -> `enable_reg_fetch=1`.
- **Requester hazard:** load_valid with addr r9 (not yet granted) and `fetch_rt_addr=9` -> stall. `fetch_rt_addr=10` -> no stall.
- **Streaming:** back-to-back ALU writes r1..r8, `wb_slot` constant 1 -> eight commits on eight consecutive edges with no bubbles.
